// File: rtl/rv32_pipeline_pkg.sv
// Shared definitions for the RV32IM pipeline: fetch FSM encoding and fetch constants.
package rv32_pipeline_pkg;

   localparam int unsigned XLEN = 32;

   // Fetch unit FSM encoding
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      READY = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RV_RESET_PC  = 32'h0000_0000;

   // Force a redirect address onto a word boundary
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-pc / next-request-address selection for the fetch unit.
module pc_next_logic
   import rv32_pipeline_pkg::*;
(
   input  fetch_state_t    state,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] req_addr,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            imem_busywait,
   output logic [XLEN-1:0] pc_next_c,
   output logic [XLEN-1:0] req_addr_next_c
);

   logic [XLEN-1:0] target_c;
   logic [XLEN-1:0] seq_addr_c;
   logic [1:0]      unused_target_lsbs;

   // Low target bits carry no information for a word-aligned fetch
   assign unused_target_lsbs = branch_target[1:0];
   assign target_c           = word_align(branch_target);
   // Sequential successor wraps modulo 2^32
   assign seq_addr_c         = req_addr + XLEN'(4);

   // Redirect beats completion; an in-flight request keeps its address until it finishes
   always_comb begin
      pc_next_c       = pc;
      req_addr_next_c = req_addr;
      case (state)
         FETCH: begin
            if (branch_taken) begin
               pc_next_c = target_c;
               if (!imem_busywait) begin
                  req_addr_next_c = target_c;
               end
            end else if (!imem_busywait) begin
               pc_next_c       = seq_addr_c;
               req_addr_next_c = seq_addr_c;
            end
         end
         READY: begin
            if (branch_taken) begin
               pc_next_c       = target_c;
               req_addr_next_c = target_c;
            end
         end
         DRAIN: begin
            if (branch_taken) begin
               pc_next_c = target_c;
            end
            if (!imem_busywait) begin
               req_addr_next_c = branch_taken ? target_c : pc;
            end
         end
         default: begin
            pc_next_c       = pc;
            req_addr_next_c = req_addr;
         end
      endcase
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, instruction-memory read handshake, single-entry instruction buffer.
module instruction_fetch_unit
   import rv32_pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RV_RESET_PC,
   parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic        IMEM_READ,
   output logic [31:0] IMEM_ADDR,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] OUT_PC,
   output logic [31:0] OUT_INSTRUCTION,
   output logic        FETCH_BUSYWAIT
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] pc_next_c;
   logic [XLEN-1:0] req_addr_next_c;
   logic [XLEN-1:0] buf_pc;
   logic [XLEN-1:0] buf_instr;
   logic            capture_c;
   logic            flush_c;

   pc_next_logic u_pc_next_logic (
      .state           (state),
      .pc              (pc),
      .req_addr        (req_addr),
      .branch_taken    (BRANCH_TAKEN),
      .branch_target   (BRANCH_TARGET),
      .imem_busywait   (IMEM_BUSYWAIT),
      .pc_next_c       (pc_next_c),
      .req_addr_next_c (req_addr_next_c)
   );

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: redirect > memory completion > stall
   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (!IMEM_BUSYWAIT && !BRANCH_TAKEN) begin
               state_next = READY;
            end else if (IMEM_BUSYWAIT && BRANCH_TAKEN) begin
               state_next = DRAIN;
            end
         end
         READY: begin
            if (BRANCH_TAKEN || !STALL) begin
               state_next = FETCH;
            end
         end
         DRAIN: begin
            if (!IMEM_BUSYWAIT) begin
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   // Handshake outputs and buffer controls; reset forces the idle handshake immediately
   always_comb begin
      IMEM_READ      = 1'b0;
      FETCH_BUSYWAIT = 1'b1;
      capture_c      = 1'b0;
      flush_c        = 1'b0;
      if (!RESET) begin
         case (state)
            FETCH: begin
               IMEM_READ = 1'b1;
               capture_c = !IMEM_BUSYWAIT && !BRANCH_TAKEN;
            end
            READY: begin
               FETCH_BUSYWAIT = 1'b0;
               flush_c        = BRANCH_TAKEN;
            end
            DRAIN: begin
               IMEM_READ = 1'b1;
            end
            default: begin
               IMEM_READ      = 1'b0;
               FETCH_BUSYWAIT = 1'b1;
            end
         endcase
      end
   end

   // PC and outstanding request address
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         pc       <= pc_next_c;
         req_addr <= req_addr_next_c;
      end
   end

   // Instruction buffer presented to IF/ID
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         buf_pc    <= '0;
         buf_instr <= NOP_INSTR;
      end else if (capture_c) begin
         buf_pc    <= req_addr;
         buf_instr <= IMEM_READDATA;
      end else if (flush_c) begin
         buf_instr <= NOP_INSTR;
      end
   end

   assign IMEM_ADDR       = req_addr;
   assign OUT_PC          = buf_pc;
   assign OUT_INSTRUCTION = buf_instr;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the RV32IM pipeline.
- Holds the program counter and runs the read handshake with the multi-cycle instruction memory/cache.
- Buffers one fetched instruction with its PC and presents it to the IF/ID pipeline register.
- Handles branch/jump redirects from EX, including redirects that arrive while a memory read is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word presented when no valid instruction is buffered (addi x0,x0,0).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  hazard-unit stall; the IF/ID register will not capture this cycle.
- BRANCH_TAKEN  input  1  redirect request from EX, sampled at posedge.
- BRANCH_TARGET  input  32  redirect address; bits [1:0] are ignored and forced to 0.
- IMEM_READ  output  1  instruction-memory read request.
- IMEM_ADDR  output  32  instruction-memory address, word aligned.
- IMEM_READDATA  input  32  instruction word, valid in a cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0.
- IMEM_BUSYWAIT  input  1  memory not ready.
- OUT_PC  output  32  PC of the buffered instruction; drives the IF/ID IN_PC.
- OUT_INSTRUCTION  output  32  buffered instruction; drives the IF/ID IN_INSTRUCTION.
- FETCH_BUSYWAIT  output  1  high when no valid instruction is presented; ORed with STALL at top level into the IF/ID BUSYWAIT.

Behaviour:
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request.
  - buf_pc, buf_instr: the presented instruction.
  - state.
- Reset (asynchronous, overrides everything, including mid-request):
  - state=FETCH, pc=req_addr=RESET_PC.
  - buf_pc=32'h0, buf_instr=NOP_INSTR.
  - While RESET is high: IMEM_READ=0, FETCH_BUSYWAIT=1, OUT_PC=0, OUT_INSTRUCTION=NOP_INSTR.
- Static output mapping: IMEM_ADDR=req_addr at all times; OUT_PC=buf_pc; OUT_INSTRUCTION=buf_instr.
- FETCH state:
  - IMEM_READ=1, FETCH_BUSYWAIT=1.
  - Posedge with IMEM_BUSYWAIT=0 and BRANCH_TAKEN=0: buf_instr<=IMEM_READDATA, buf_pc<=req_addr, pc<=req_addr+4, req_addr<=req_addr+4, go to READY.
  - Posedge with IMEM_BUSYWAIT=0 and BRANCH_TAKEN=1: discard the data; pc<=req_addr<=target; stay in FETCH.
  - Posedge with IMEM_BUSYWAIT=1 and BRANCH_TAKEN=1: pc<=target, req_addr unchanged (request must complete), go to DRAIN.
  - STALL is ignored in FETCH.
- READY state:
  - IMEM_READ=0, FETCH_BUSYWAIT=0.
  - Posedge with BRANCH_TAKEN=1: buf_instr<=NOP_INSTR, pc<=req_addr<=target, go to FETCH.
  - Posedge with STALL=0: the IF/ID register captures the instruction; go to FETCH (req_addr already equals pc).
  - Posedge with STALL=1: hold all state.
- DRAIN state:
  - IMEM_READ=1 at the old req_addr, FETCH_BUSYWAIT=1.
  - Posedge with IMEM_BUSYWAIT=0: drop the data, req_addr<=pc, go to FETCH.
  - A further BRANCH_TAKEN in DRAIN overwrites pc with the newest target (last redirect wins).
- Priority: RESET > BRANCH_TAKEN > memory completion > STALL.
- Width and timing rules:
  - All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
  - Latency from request accept to presented instruction is 1 cycle after the memory drops IMEM_BUSYWAIT.
  - With a zero-wait memory, steady-state throughput is one instruction every 2 cycles.
- Invariants (assertable):
  - IMEM_ADDR is stable while IMEM_READ=1 and IMEM_BUSYWAIT=1.
  - IMEM_ADDR[1:0]==0.
  - No instruction fetched before a redirect ever reaches READY.

Decomposition:
- Shared package rv32_pipeline_pkg holds:
  - fetch state encoding (FETCH=2'd0, READY=2'd1, DRAIN=2'd2),
  - NOP_INSTR constant,
  - RESET_PC default.
- One natural sub-module, pc_next_logic: combinational next-pc and next-req_addr selection from state and events.
- The FSM and buffer registers stay in the top module.

Test Plan:
- Reset then zero-wait memory returning addr-derived words:
  - Expected sequence: OUT_PC 0x0, 0x4, 0x8 with FETCH_BUSYWAIT low every other cycle.
  - IMEM_ADDR 0x0→0x4→0x8.
- Memory with 3-cycle busywait: IMEM_ADDR holds 0x4 for all busy cycles; the instruction at 0x4 is presented 1 cycle after busywait drops.
- STALL=1 for 4 cycles while in READY with buf_pc=0x8:
  - OUT_PC/OUT_INSTRUCTION hold.
  - IMEM_READ stays 0.
  - The fetch of 0xC starts the cycle after STALL falls.
- BRANCH_TAKEN with target 0x103 while a fetch of 0x10 is busy:
  - IMEM_ADDR stays 0x10 until busywait drops; that data is never presented.
  - The next request goes to 0x100.
  - OUT_PC=0x100 next.
- BRANCH_TAKEN in READY with STALL=1: the buffer becomes NOP, the next request is to the target, and the stale instruction is never presented again.
- Asynchronous RESET asserted mid-DRAIN: outputs go to reset values immediately without waiting for CLK; after release, the first request is at RESET_PC. Also start at pc=0xFFFF_FFFC and check the following fetch wraps to 0x0.
